alu_console_ctrl: RTL and testbench

- Parametrised operator-console sequencer for the FPGA ALU demo.
- Collects operands A and B, the ALU op code and a destination register index from slide switches. Each value is entered with one debounced push-button press/release.
- Writes the ALU result into the register file, then drives the register renderer start/done handshake with a watchdog timeout.
- Sits between board I/O (KEY/SW/LEDR), the alu, register_file and register_renderer in the top level.

---
 rtl/alu_console_ctrl_pkg.sv | 52 +++++
 rtl/alu_console_ctrl_if.sv | 38 +++
 rtl/alu_console_ctrl_key_debounce.sv | 60 ++++++
 rtl/alu_console_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_console_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_console_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_console_pkg
// Shared definitions for the ALU operator-console sequencer:
//   - 4-bit state encodings, also shown on the LEDs
//   - SIGN_EXT helper that widens a switch word to the datapath width
// No ports; imported by alu_console_ctrl and its testbench.
// -----------------------------------------------------------------------------
package alu_console_pkg;

    localparam logic [3:0] ST_WAIT_A      = 4'd0;
    localparam logic [3:0] ST_HOLD_A      = 4'd1;
    localparam logic [3:0] ST_WAIT_B      = 4'd2;
    localparam logic [3:0] ST_HOLD_B      = 4'd3;
    localparam logic [3:0] ST_WAIT_OP     = 4'd4;
    localparam logic [3:0] ST_HOLD_OP     = 4'd5;
    localparam logic [3:0] ST_WAIT_RD     = 4'd6;
    localparam logic [3:0] ST_HOLD_RD     = 4'd7;
    localparam logic [3:0] ST_WRITE       = 4'd8;
    localparam logic [3:0] ST_START       = 4'd9;
    localparam logic [3:0] ST_WAIT_RENDER = 4'd10;
    localparam logic [3:0] ST_DONE        = 4'd11;
    localparam logic [3:0] ST_ERR         = 4'd15;

    typedef enum logic [3:0] {
        S_WAIT_A      = ST_WAIT_A,
        S_HOLD_A      = ST_HOLD_A,
        S_WAIT_B      = ST_WAIT_B,
        S_HOLD_B      = ST_HOLD_B,
        S_WAIT_OP     = ST_WAIT_OP,
        S_HOLD_OP     = ST_HOLD_OP,
        S_WAIT_RD     = ST_WAIT_RD,
        S_HOLD_RD     = ST_HOLD_RD,
        S_WRITE       = ST_WRITE,
        S_START       = ST_START,
        S_WAIT_RENDER = ST_WAIT_RENDER,
        S_DONE        = ST_DONE,
        S_ERR         = ST_ERR
    } state_t;

    // Widest word SIGN_EXT can handle; callers cast the result to their width.
    localparam int unsigned EXT_W = 64;

    // Sign-extend the low src_w bits of val: move the sign bit to the top,
    // then arithmetic-shift back down.
    function automatic logic signed [EXT_W-1:0] SIGN_EXT(input logic [EXT_W-1:0] val,
                                                         input int unsigned      src_w);
        logic signed [EXT_W-1:0] t;
        t = $signed(val << (EXT_W - src_w));
        return t >>> (EXT_W - src_w);
    endfunction

endpackage

// File: rtl/alu_console_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_console_ctrl_if
// Bundles the sequencer's connections to the ALU, register file and register
// renderer.
//   master (sequencer): drives alu_src_a/b, alu_op, rf_w_*, rr_start, rr_rst_n;
//                       receives alu_result, rr_done
//   slave  (datapath) : the mirror image
// -----------------------------------------------------------------------------
interface alu_console_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int OP_W  = 4,
    parameter int RF_AW = 5
);
    logic [XLEN-1:0]  alu_src_a;
    logic [XLEN-1:0]  alu_src_b;
    logic [OP_W-1:0]  alu_op;
    logic [XLEN-1:0]  alu_result;
    logic             rf_w_en;
    logic [RF_AW-1:0] rf_w_addr;
    logic [XLEN-1:0]  rf_w_data;
    logic             rr_start;
    logic             rr_done;
    logic             rr_rst_n;

    modport master (
        output alu_src_a, alu_src_b, alu_op,
        output rf_w_en, rf_w_addr, rf_w_data,
        output rr_start, rr_rst_n,
        input  alu_result, rr_done
    );

    modport slave (
        input  alu_src_a, alu_src_b, alu_op,
        input  rf_w_en, rf_w_addr, rf_w_data,
        input  rr_start, rr_rst_n,
        output alu_result, rr_done
    );
endinterface

// File: rtl/alu_console_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises a raw active-low push button and debounces it. The debounced
// level flips only after DEB_CYC consecutive synchronised samples disagree with
// it; any agreeing sample restarts the count.
//   clk, rst  : clock, asynchronous active-low reset (button reads released)
//   key_n_i   : raw button, active-low, asynchronous to clk
//   press_o   : one-cycle pulse on the debounced falling edge
//   release_o : one-cycle pulse on the debounced rising edge
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o,
    output logic release_o
);
    localparam int               CNT_W    = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ, accept;

    assign differ = sync2_q ^ level_q;
    // The DEB_CYC-th disagreeing sample is the one that flips the level.
    assign accept = differ && (cnt_q == CNT_LAST);

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (accept) begin
            level_d = sync2_q;
        end else if (differ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses are decoded in the cycle the flip is accepted, so the consumer
    // reacts on the same edge that updates level_q.
    assign press_o   = accept &  level_q;
    assign release_o = accept & ~level_q;
endmodule

// File: rtl/alu_console_ctrl.sv
// -----------------------------------------------------------------------------
// alu_console_ctrl
// Operator-console sequencer for the FPGA ALU demo. Four button presses enter
// operand A, operand B, the ALU op code and the destination register from the
// switches. The ALU result is then written to the register file and the
// register renderer is started under a watchdog.
//   clk, rst : clock, asynchronous active-low reset
//   key_n    : raw push button (active-low, asynchronous)
//   sw       : raw switches, captured on the debounced release
//   bus      : ALU / register-file / renderer connections (master modport)
//   busy     : high from WRITE through DONE
//   err      : sticky render-timeout flag, cleared only by rst
//   state    : current state encoding for the LEDs
// -----------------------------------------------------------------------------
module alu_console_ctrl
    import alu_console_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SW_W    = 10,
    parameter int OP_W    = 4,
    parameter int RF_AW   = 5,
    parameter int DEB_CYC = 16,
    parameter int TMO_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_n,
    input  logic [SW_W-1:0]   sw,
    alu_console_ctrl_if.master bus,
    output logic              busy,
    output logic              err,
    output logic [3:0]        state
);
    logic press, release_p;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key (
        .clk       (clk),
        .rst       (rst),
        .key_n_i   (key_n),
        .press_o   (press),
        .release_o (release_p)
    );

    logic signed [XLEN-1:0] sw_sext;
    assign sw_sext = XLEN'(SIGN_EXT(EXT_W'(sw), SW_W));

    state_t                 state_q;
    logic signed [XLEN-1:0] src_a_q, src_b_q;
    logic [OP_W-1:0]        op_q;
    logic [RF_AW-1:0]       rd_q;
    logic                   wen_q;
    logic [XLEN-1:0]        wdata_q;
    logic                   start_q;
    logic                   rrn_q;
    logic                   err_q;
    logic [TMO_W-1:0]       wdg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT_A;
            src_a_q <= '0;
            src_b_q <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            start_q <= 1'b0;
            rrn_q   <= 1'b1;
            err_q   <= 1'b0;
            wdg_q   <= '0;
        end else begin
            // Write strobe and renderer reset are one-cycle pulses.
            wen_q <= 1'b0;
            rrn_q <= 1'b1;
            case (state_q)
                S_WAIT_A:  if (press) state_q <= S_HOLD_A;
                S_HOLD_A:  if (release_p) begin
                    src_a_q <= sw_sext;
                    state_q <= S_WAIT_B;
                end
                S_WAIT_B:  if (press) state_q <= S_HOLD_B;
                S_HOLD_B:  if (release_p) begin
                    src_b_q <= sw_sext;
                    state_q <= S_WAIT_OP;
                end
                S_WAIT_OP: if (press) state_q <= S_HOLD_OP;
                S_HOLD_OP: if (release_p) begin
                    op_q    <= sw[OP_W-1:0];
                    state_q <= S_WAIT_RD;
                end
                S_WAIT_RD: if (press) state_q <= S_HOLD_RD;
                S_HOLD_RD: if (release_p) begin
                    // Op and operands are already stable, so the ALU result can
                    // be latched together with rd; x0 is never written.
                    rd_q    <= sw[RF_AW-1:0];
                    wen_q   <= (sw[RF_AW-1:0] != '0);
                    wdata_q <= bus.alu_result;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    wdg_q   <= '0;
                    state_q <= S_WAIT_RENDER;
                end
                S_WAIT_RENDER: begin
                    // Done is checked first so it wins over a simultaneous timeout.
                    if (bus.rr_done) begin
                        start_q <= 1'b0;
                        rrn_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (wdg_q == '1) begin
                        err_q   <= 1'b1;
                        start_q <= 1'b0;
                        rrn_q   <= 1'b0;
                        state_q <= S_ERR;
                    end else begin
                        wdg_q <= wdg_q + 1'b1;
                    end
                end
                S_DONE:    state_q <= S_WAIT_A;
                S_ERR:     if (press) state_q <= S_WAIT_A;
                default: begin
                    err_q   <= 1'b1;
                    start_q <= 1'b0;
                    state_q <= S_ERR;
                end
            endcase
        end
    end

    assign bus.alu_src_a = src_a_q;
    assign bus.alu_src_b = src_b_q;
    assign bus.alu_op    = op_q;
    assign bus.rf_w_en   = wen_q;
    assign bus.rf_w_addr = rd_q;
    assign bus.rf_w_data = wdata_q;
    assign bus.rr_start  = start_q;
    assign bus.rr_rst_n  = rrn_q;

    assign busy  = (state_q == S_WRITE) || (state_q == S_START) ||
                   (state_q == S_WAIT_RENDER) || (state_q == S_DONE);
    assign err   = err_q;
    assign state = state_q;
endmodule

// File: tb/tb_alu_console_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_console_ctrl
// Directed bench for alu_console_ctrl with DEB_CYC=4, TMO_W=6. Inputs change
// and outputs are sampled 2 ns after the rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_console_ctrl;
    import alu_console_pkg::*;

    localparam int XLEN    = 32;
    localparam int SW_W    = 10;
    localparam int OP_W    = 4;
    localparam int RF_AW   = 5;
    localparam int DEB_CYC = 4;
    localparam int TMO_W   = 6;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            key_n = 1'b1;
    logic [SW_W-1:0] sw    = '0;
    logic            busy, err;
    logic [3:0]      state;

    alu_console_ctrl_if #(.XLEN(XLEN), .OP_W(OP_W), .RF_AW(RF_AW)) bus ();

    alu_console_ctrl #(
        .XLEN(XLEN), .SW_W(SW_W), .OP_W(OP_W), .RF_AW(RF_AW),
        .DEB_CYC(DEB_CYC), .TMO_W(TMO_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .sw    (sw),
        .bus   (bus),
        .busy  (busy),
        .err   (err),
        .state (state)
    );

    always #5 clk = ~clk;

    // Tiny ALU: op 0 adds, anything else subtracts.
    assign bus.alu_result = (bus.alu_op == '0) ? bus.alu_src_a + bus.alu_src_b
                                               : bus.alu_src_a - bus.alu_src_b;

    int n_vec  = 0;
    int n_miss = 0;

    // Activity counters for one-cycle pulses.
    int wen_cnt    = 0;
    int rrn_lo_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rf_w_en) wen_cnt++;
            if (!bus.rr_rst_n) rrn_lo_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Press is accepted 6 edges after key_n falls; 8 leaves margin.
    task automatic key_down(input logic [SW_W-1:0] v);
        sw    = v;
        key_n = 1'b0;
        cyc(8);
    endtask

    // Release is accepted 6 edges after key_n rises; after 8 edges a rd entry
    // has reached its first WAIT_RENDER cycle.
    task automatic tap(input logic [SW_W-1:0] v);
        key_down(v);
        key_n = 1'b1;
        cyc(8);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    int w0, r0, n;

    initial begin
        bus.rr_done = 1'b0;
        cyc(3);

        // Reset state
        chk("rst_state",    state,         ST_WAIT_A);
        chk("rst_rr_rst_n", bus.rr_rst_n,  1);
        chk("rst_rr_start", bus.rr_start,  0);
        chk("rst_wen",      bus.rf_w_en,   0);
        chk("rst_src_a",    bus.alu_src_a, 0);
        chk("rst_busy",     busy,          0);
        chk("rst_err",      err,           0);
        rst = 1'b1;
        cyc(2);

        // Full sequence: 5 + (-1) -> x3
        tap(10'h005);
        chk("a_state", state,         ST_WAIT_B);
        chk("a_val",   bus.alu_src_a, 32'h0000_0005);
        tap(10'h3FF);
        chk("b_state", state,         ST_WAIT_OP);
        chk("b_val",   bus.alu_src_b, 32'hFFFF_FFFF);
        tap(10'h000);
        chk("op_state", state,      ST_WAIT_RD);
        chk("op_val",   bus.alu_op, 0);
        w0 = wen_cnt;
        r0 = rrn_lo_cnt;
        key_down(10'h003);
        chk("rd_hold", state, ST_HOLD_RD);
        key_n = 1'b1;
        cyc(5);
        chk("rd_pre_state", state,       ST_HOLD_RD);
        chk("rd_pre_wen",   bus.rf_w_en, 0);
        cyc(1);
        chk("wr_state", state,          ST_WRITE);
        chk("wr_wen",   bus.rf_w_en,    1);
        chk("wr_addr",  bus.rf_w_addr,  3);
        chk("wr_data",  bus.rf_w_data,  32'h0000_0004);
        chk("wr_busy",  busy,           1);
        chk("wr_start", bus.rr_start,   0);
        cyc(1);
        chk("st_wen",   bus.rf_w_en,  0);
        chk("st_start", bus.rr_start, 1);
        chk("st_state", state,        ST_START);
        cyc(1);
        chk("wr_render_state", state, ST_WAIT_RENDER);
        cyc(5);
        chk("render_hold_start", bus.rr_start, 1);
        bus.rr_done = 1'b1;
        cyc(1);
        bus.rr_done = 1'b0;
        chk("done_state", state,        ST_DONE);
        chk("done_start", bus.rr_start, 0);
        chk("done_rrn",   bus.rr_rst_n, 0);
        cyc(1);
        chk("ret_state", state,         ST_WAIT_A);
        chk("ret_rrn",   bus.rr_rst_n,  1);
        chk("ret_busy",  busy,          0);
        chk("ret_src_a", bus.alu_src_a, 32'h0000_0005);
        chk("ret_src_b", bus.alu_src_b, 32'hFFFF_FFFF);
        chk("seq_wen_pulses", wen_cnt - w0,    1);
        chk("seq_rrn_pulses", rrn_lo_cnt - r0, 1);

        // Reset asserted while rendering
        tap(10'h001);
        tap(10'h002);
        tap(10'h001);
        tap(10'h005);
        chk("mid_pre_state", state,        ST_WAIT_RENDER);
        chk("mid_pre_start", bus.rr_start, 1);
        rst = 1'b0;
        #1;
        chk("mid_state", state,         ST_WAIT_A);
        chk("mid_start", bus.rr_start,  0);
        chk("mid_rrn",   bus.rr_rst_n,  1);
        chk("mid_src_a", bus.alu_src_a, 0);
        chk("mid_op",    bus.alu_op,    0);
        chk("mid_busy",  busy,          0);
        cyc(2);
        rst = 1'b1;
        cyc(2);

        // Bouncing key: only the final stable low is accepted
        for (int i = 0; i < 10; i++) begin
            key_n = ~key_n;
            cyc(2);
        end
        chk("bounce_idle", state, ST_WAIT_A);
        key_n = 1'b0;
        cyc(5);
        chk("bounce_early", state, ST_WAIT_A);
        cyc(1);
        chk("bounce_hold", state, ST_HOLD_A);
        cyc(10);
        chk("bounce_single", state, ST_HOLD_A);
        key_n = 1'b1;
        cyc(8);
        chk("bounce_release", state, ST_WAIT_B);
        do_reset();

        // rd = 0: no write, sequence continues
        tap(10'h001);
        tap(10'h002);
        tap(10'h000);
        w0 = wen_cnt;
        tap(10'h000);
        chk("rd0_state", state,        ST_WAIT_RENDER);
        chk("rd0_start", bus.rr_start, 1);
        bus.rr_done = 1'b1;
        cyc(1);
        bus.rr_done = 1'b0;
        chk("rd0_done", state, ST_DONE);
        cyc(1);
        chk("rd0_ret",  state,        ST_WAIT_A);
        chk("rd0_wen",  wen_cnt - w0, 0);

        // Watchdog expiry
        tap(10'h001);
        tap(10'h002);
        tap(10'h000);
        r0 = rrn_lo_cnt;
        tap(10'h007);
        chk("wdg_enter", state, ST_WAIT_RENDER);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (state == ST_WAIT_RENDER) n++;
            else break;
        end
        chk("wdg_cycles", n,            64);
        chk("wdg_state",  state,        ST_ERR);
        chk("wdg_err",    err,          1);
        chk("wdg_start",  bus.rr_start, 0);
        chk("wdg_rrn",    bus.rr_rst_n, 0);
        chk("wdg_busy",   busy,         0);
        cyc(1);
        chk("wdg_rrn_end",    bus.rr_rst_n,    1);
        chk("wdg_state_hold", state,           ST_ERR);
        chk("wdg_rrn_pulses", rrn_lo_cnt - r0, 1);
        key_down(10'h000);
        chk("err_exit_state", state, ST_WAIT_A);
        chk("err_sticky",     err,   1);
        key_n = 1'b1;
        cyc(8);
        chk("err_sticky_rel", err,   1);
        chk("err_rel_state",  state, ST_WAIT_A);

        // Done in the terminal-count cycle wins
        do_reset();
        chk("bnd_err_clr", err, 0);
        tap(10'h001);
        tap(10'h002);
        tap(10'h000);
        tap(10'h009);
        chk("bnd_enter", state, ST_WAIT_RENDER);
        cyc(63);
        chk("bnd_last", state, ST_WAIT_RENDER);
        bus.rr_done = 1'b1;
        cyc(1);
        bus.rr_done = 1'b0;
        chk("bnd_state", state, ST_DONE);
        chk("bnd_err",   err,   0);
        cyc(1);
        chk("bnd_ret", state, ST_WAIT_A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
